// File: rtl/ram_port_arbiter_if.sv
// Bundle of the IF/LS requester handshakes and the core-side RAM port seen by ram_port_arbiter.
// slave is the arbiter's view; master is the environment's (requesters + RAM) view.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  if_req_valid_i;
  logic                  if_req_ready_o;
  logic [ADDR_W-1:0]     if_addr_i;
  logic [2:0]            if_size_i;
  logic                  if_rsp_valid_o;
  logic [DATA_W-1:0]     if_rsp_data_o;
  logic                  if_rsp_err_o;

  logic                  ls_req_valid_i;
  logic                  ls_req_ready_o;
  logic                  ls_we_i;
  logic [ADDR_W-1:0]     ls_addr_i;
  logic [DATA_W-1:0]     ls_wdata_i;
  logic [DATA_W/8-1:0]   ls_wmask_i;
  logic [2:0]            ls_size_i;
  logic                  ls_rsp_valid_o;
  logic [DATA_W-1:0]     ls_rsp_data_o;
  logic                  ls_rsp_err_o;

  logic                  ram_cen_o;
  logic                  ram_wen_o;
  logic [ADDR_W-1:0]     ram_addr_o;
  logic [DATA_W-1:0]     ram_wdata_o;
  logic [DATA_W/8-1:0]   ram_wmask_o;
  logic [2:0]            ram_size_o;
  logic                  ram_ready_i;
  logic [DATA_W-1:0]     ram_rdata_i;

  modport slave (
    input  if_req_valid_i, if_addr_i, if_size_i,
    input  ls_req_valid_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i, ls_size_i,
    input  ram_ready_i, ram_rdata_i,
    output if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, if_rsp_err_o,
    output ls_req_ready_o, ls_rsp_valid_o, ls_rsp_data_o, ls_rsp_err_o,
    output ram_cen_o, ram_wen_o, ram_addr_o, ram_wdata_o, ram_wmask_o, ram_size_o
  );

  modport master (
    output if_req_valid_i, if_addr_i, if_size_i,
    output ls_req_valid_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i, ls_size_i,
    output ram_ready_i, ram_rdata_i,
    input  if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, if_rsp_err_o,
    input  ls_req_ready_o, ls_rsp_valid_o, ls_rsp_data_o, ls_rsp_err_o,
    input  ram_cen_o, ram_wen_o, ram_addr_o, ram_wdata_o, ram_wmask_o, ram_size_o
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between instruction fetch (IF) and load/store (LS).
// Each access: one-cycle enable pulse, bounded wait for ready, one-cycle registered response.
module ram_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input logic               clock,
  input logic               reset,
  ram_port_arbiter_if.slave bus
);
  localparam int         MASK_W   = DATA_W / 8;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                prio_ls_r;
  logic                owner_ls_r;
  logic                owner_we_r;
  logic [7:0]          cnt_r;
  logic [7:0]          cnt_nxt_s;
  logic                grant_if_s;
  logic                grant_ls_s;
  logic                done_s;
  logic                timeout_s;

  logic                ram_cen_r;
  logic                ram_wen_r;
  logic [ADDR_W-1:0]   ram_addr_r;
  logic [DATA_W-1:0]   ram_wdata_r;
  logic [MASK_W-1:0]   ram_wmask_r;
  logic [2:0]          ram_size_r;

  logic                if_rsp_valid_r;
  logic [DATA_W-1:0]   if_rsp_data_r;
  logic                if_rsp_err_r;
  logic                ls_rsp_valid_r;
  logic [DATA_W-1:0]   ls_rsp_data_r;
  logic                ls_rsp_err_r;

  // Arbitration, next state and wait-counter; grants are suppressed while reset is held.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    grant_if_s  = 1'b0;
    grant_ls_s  = 1'b0;
    done_s      = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = 8'd0;
        if (!reset && bus.ls_req_valid_i && (prio_ls_r || !bus.if_req_valid_i)) begin
          grant_ls_s  = 1'b1;
          state_nxt_s = ISSUE;
        end else if (!reset && bus.if_req_valid_i) begin
          grant_if_s  = 1'b1;
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        cnt_nxt_s = 8'd0;
        if (bus.ram_ready_i) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt_s = cnt_r + 8'd1;
        if (bus.ram_ready_i) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else if (cnt_nxt_s == CNT_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counter, ownership and round-robin priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      prio_ls_r  <= 1'b1;
      owner_ls_r <= 1'b0;
      owner_we_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (grant_if_s) begin
        owner_ls_r <= 1'b0;
        owner_we_r <= 1'b0;
        prio_ls_r  <= 1'b1;
      end else if (grant_ls_s) begin
        owner_ls_r <= 1'b1;
        owner_we_r <= bus.ls_we_i;
        prio_ls_r  <= 1'b0;
      end else begin
        owner_ls_r <= owner_ls_r;
        owner_we_r <= owner_we_r;
        prio_ls_r  <= prio_ls_r;
      end
    end
  end

  // RAM request registers; enable and write-enable live only for the ISSUE cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_cen_r   <= 1'b0;
      ram_wen_r   <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_wdata_r <= {DATA_W{1'b0}};
      ram_wmask_r <= {MASK_W{1'b0}};
      ram_size_r  <= 3'd0;
    end else if (grant_ls_s) begin
      ram_cen_r   <= 1'b1;
      ram_wen_r   <= bus.ls_we_i;
      ram_addr_r  <= bus.ls_addr_i;
      ram_wdata_r <= bus.ls_we_i ? bus.ls_wdata_i : {DATA_W{1'b0}};
      ram_wmask_r <= bus.ls_we_i ? bus.ls_wmask_i : {MASK_W{1'b0}};
      ram_size_r  <= bus.ls_size_i;
    end else if (grant_if_s) begin
      ram_cen_r   <= 1'b1;
      ram_wen_r   <= 1'b0;
      ram_addr_r  <= bus.if_addr_i;
      ram_wdata_r <= {DATA_W{1'b0}};
      ram_wmask_r <= {MASK_W{1'b0}};
      ram_size_r  <= bus.if_size_i;
    end else begin
      ram_cen_r   <= 1'b0;
      ram_wen_r   <= 1'b0;
    end
  end

  // Responses: owner's valid pulses once; data/err hold until that owner's next completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      if_rsp_valid_r <= 1'b0;
      if_rsp_data_r  <= {DATA_W{1'b0}};
      if_rsp_err_r   <= 1'b0;
      ls_rsp_valid_r <= 1'b0;
      ls_rsp_data_r  <= {DATA_W{1'b0}};
      ls_rsp_err_r   <= 1'b0;
    end else if ((done_s || timeout_s) && owner_ls_r) begin
      if_rsp_valid_r <= 1'b0;
      ls_rsp_valid_r <= 1'b1;
      ls_rsp_err_r   <= timeout_s;
      ls_rsp_data_r  <= (timeout_s || owner_we_r) ? {DATA_W{1'b0}} : bus.ram_rdata_i;
    end else if (done_s || timeout_s) begin
      ls_rsp_valid_r <= 1'b0;
      if_rsp_valid_r <= 1'b1;
      if_rsp_err_r   <= timeout_s;
      if_rsp_data_r  <= timeout_s ? {DATA_W{1'b0}} : bus.ram_rdata_i;
    end else begin
      if_rsp_valid_r <= 1'b0;
      ls_rsp_valid_r <= 1'b0;
    end
  end

  assign bus.if_req_ready_o = grant_if_s;
  assign bus.ls_req_ready_o = grant_ls_s;
  assign bus.ram_cen_o      = ram_cen_r;
  assign bus.ram_wen_o      = ram_wen_r;
  assign bus.ram_addr_o     = ram_addr_r;
  assign bus.ram_wdata_o    = ram_wdata_r;
  assign bus.ram_wmask_o    = ram_wmask_r;
  assign bus.ram_size_o     = ram_size_r;
  assign bus.if_rsp_valid_o = if_rsp_valid_r;
  assign bus.if_rsp_data_o  = if_rsp_data_r;
  assign bus.if_rsp_err_o   = if_rsp_err_r;
  assign bus.ls_rsp_valid_o = ls_rsp_valid_r;
  assign bus.ls_rsp_data_o  = ls_rsp_data_r;
  assign bus.ls_rsp_err_o   = ls_rsp_err_r;
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single core-side RAM read/write port (cen/wen/addr/wdata/wmask/size in; ready/rdata back) between the instruction-fetch requester (IF) and the load/store requester (LS).
- Sequences each access as one transaction: a one-cycle enable pulse, then a wait for ready, then a registered response to the owning requester.
- Resolves conflicts round-robin and bounds every wait with a timeout that returns an error response.
- Sits inside rvcpu between the IFU/LSU and the RAM interface ports.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; wmask width is DATA_W/8.
- TIMEOUT, 16, maximum cycles in WAIT before an error response; legal range 2..255.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- if_req_valid_i  in  1  IF read request.
- if_req_ready_o  out  1  IF request accepted this cycle.
- if_addr_i  in  ADDR_W  IF address.
- if_size_i  in  3  IF access size.
- if_rsp_valid_o  out  1  IF response pulse.
- if_rsp_data_o  out  DATA_W  IF read data.
- if_rsp_err_o  out  1  IF timeout error.
- ls_req_valid_i  in  1  LS request.
- ls_req_ready_o  out  1  LS request accepted.
- ls_we_i  in  1  LS write (1) / read (0).
- ls_addr_i  in  ADDR_W  LS address.
- ls_wdata_i  in  DATA_W  LS write data.
- ls_wmask_i  in  DATA_W/8  LS byte mask.
- ls_size_i  in  3  LS access size.
- ls_rsp_valid_o  out  1  LS response pulse.
- ls_rsp_data_o  out  DATA_W  LS read data; 0 for writes.
- ls_rsp_err_o  out  1  LS timeout error.
- ram_cen_o  out  1  RAM enable.
- ram_wen_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_wdata_o  out  DATA_W  RAM write data.
- ram_wmask_o  out  DATA_W/8  RAM byte mask.
- ram_size_o  out  3  RAM access size.
- ram_ready_i  in  1  RAM done.
- ram_rdata_i  in  DATA_W  RAM read data.

Behaviour:
- Reset:
  - state = IDLE; prio_ls = 1 (LS wins the first conflict); timeout counter = 0; owner = IF.
  - All outputs 0.
  - Reset mid-transaction aborts it silently: no response is emitted, and ram_cen_o drops the next cycle.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, arbitration (req_ready_o is combinational):
  - Only one requester valid: that requester is granted.
  - Both valid: LS is granted if prio_ls = 1, otherwise IF.
  - Granted req_ready_o = 1 only in IDLE; the non-granted ready stays 0.
  - On grant, latch owner and the request fields into RAM output registers, then go to ISSUE.
  - prio_ls is set to (granted requester == IF), so the other requester wins the next conflict.
- Request field latching:
  - IF grant: ram_wen_o = 0, ram_wdata_o = 0, ram_wmask_o = 0.
  - LS grant: ram_wen_o = ls_we_i; ram_wdata_o and ram_wmask_o are taken from the LS inputs when ls_we_i = 1, otherwise 0.
- ISSUE (exactly one cycle):
  - ram_cen_o = 1 and ram_wen_o as latched, so a write is performed exactly once.
  - Next state is WAIT, except that ram_ready_i = 1 in ISSUE completes the transaction immediately.
- WAIT:
  - ram_cen_o = 0; RAM address and size outputs are held.
  - Counter increments each cycle.
  - ram_ready_i = 1: register the response and go to IDLE.
  - Counter reaches TIMEOUT-1 with no ready: error response with data 0, go to IDLE.
- Response:
  - Owner's rsp_valid_o pulses high for exactly one cycle, the cycle after completion.
  - rsp_data_o = ram_rdata_i sampled at completion for reads, 0 for writes; rsp_err_o as above.
  - Non-owner response outputs stay 0.
  - Data outputs hold their last value; only valid is a pulse.
- Back-to-back: the response pulse cycle is an IDLE cycle, so a new grant may occur in that same cycle. This gives a minimum issue spacing of 3 cycles with the 1-cycle-latency RAM.
- ram_ready_i is ignored in IDLE. A late ready after a timeout that arrives in the next transaction's ISSUE is indistinguishable from a real completion; the RAM contract forbids it.
- Requesters hold their fields stable only in the accept cycle; the arbiter never re-samples them.
- Latency with the registered 1-cycle RAM, request accepted at cycle N:
  - cen at N+1;
  - ready at N+2;
  - rsp_valid at N+3.

Test Plan:
- IF read, addr 0x80000000, RAM returns 0x00000013_00000297 one cycle after cen:
  - if_req_ready_o = 1 at N; ram_cen_o = 1 only at N+1 with ram_wen_o = 0;
  - if_rsp_valid_o = 1 at N+3 with that data; ls_rsp_valid_o stays 0.
- LS write, addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F:
  - ram_wen_o and ram_cen_o each high exactly one cycle; ram_wmask_o = 0x0F;
  - ls_rsp_valid_o pulses with data 0 and err 0.
- Both request every cycle from reset for 4 transactions:
  - grants alternate LS, IF, LS, IF; the losing ready stays 0;
  - each response goes only to its owner.
- RAM never asserts ready, TIMEOUT = 16:
  - rsp_valid_o with err = 1 and data 0 exactly 16 cycles after ISSUE;
  - arbiter returns to IDLE and accepts a new request.
- Reset asserted in WAIT of an LS read:
  - the next cycle has all outputs 0 and state IDLE;
  - no ls_rsp_valid_o occurs afterwards.
- Spurious ram_ready_i in IDLE with no request: no response and no state change.
